ps2_scancode_decoder: RTL and testbench

- Consumes raw PS/2 scan-code bytes from the keyboard receiver stage. Input is one byte per single-cycle strobe.
- Resolves Set-2 prefixes: E0 marks an extended key, F0 marks a break (release).
- Emits one make/break event per key action into a small first-word-fall-through event FIFO.
- Sits between the PS/2 byte receiver and the game/display control logic.

---
 rtl/ps2_pkg.sv | 67 ++++++
 rtl/ps2_event_fifo.sv | 62 ++++++
 rtl/ps2_scancode_decoder.sv | 162 ++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and event layout for the PS/2 Set-2 scan-code decoder.
// The SCANCODE_ASCII_EN macro adds an ASCII field to the event and the Set-2 lookup helper.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Keyboard-to-host protocol bytes that never represent a key.
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GOT_E0   = 2'd1;
    localparam logic [1:0] ST_GOT_F0   = 2'd2;
    localparam logic [1:0] ST_GOT_E0F0 = 2'd3;

    localparam int CODE_W  = 8;
    localparam int ASCII_W = 8;

    typedef struct packed {
`ifdef SCANCODE_ASCII_EN
        logic [ASCII_W-1:0] ascii;
`endif
        logic               ext;
        logic               brk;
        logic [CODE_W-1:0]  code;
    } ps2_event_t;

    function automatic logic is_control_byte(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
               (b == PS2_ACK)  || (b == PS2_RESEND) || (b == PS2_ERR1);
    endfunction

`ifdef SCANCODE_ASCII_EN
    function automatic logic [7:0] ascii_lookup(input logic [7:0] code, input logic shift);
        logic [7:0] ch;
        case (code)
            8'h1C: ch = 8'h61; 8'h32: ch = 8'h62; 8'h21: ch = 8'h63; 8'h23: ch = 8'h64;
            8'h24: ch = 8'h65; 8'h2B: ch = 8'h66; 8'h34: ch = 8'h67; 8'h33: ch = 8'h68;
            8'h43: ch = 8'h69; 8'h3B: ch = 8'h6A; 8'h42: ch = 8'h6B; 8'h4B: ch = 8'h6C;
            8'h3A: ch = 8'h6D; 8'h31: ch = 8'h6E; 8'h44: ch = 8'h6F; 8'h4D: ch = 8'h70;
            8'h15: ch = 8'h71; 8'h2D: ch = 8'h72; 8'h1B: ch = 8'h73; 8'h2C: ch = 8'h74;
            8'h3C: ch = 8'h75; 8'h2A: ch = 8'h76; 8'h1D: ch = 8'h77; 8'h22: ch = 8'h78;
            8'h35: ch = 8'h79; 8'h1A: ch = 8'h7A;
            8'h45: ch = 8'h30; 8'h16: ch = 8'h31; 8'h1E: ch = 8'h32; 8'h26: ch = 8'h33;
            8'h25: ch = 8'h34; 8'h2E: ch = 8'h35; 8'h36: ch = 8'h36; 8'h3D: ch = 8'h37;
            8'h3E: ch = 8'h38; 8'h46: ch = 8'h39;
            8'h29: ch = 8'h20;
            8'h5A: ch = 8'h0D;
            default: ch = 8'h00;
        endcase
        // Only letters change case; digits, space and enter ignore shift.
        if (shift && (ch >= 8'h61) && (ch <= 8'h7A)) begin
            ch = ch - 8'h20;
        end
        return ch;
    endfunction
`endif

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; head is driven straight from storage.
// When full, a push alongside a pop is accepted; a lone push is dropped and flagged.
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic             dropped
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dropped = push & ~do_push;

    // Gate the head so the unreset storage never leaks onto the outputs.
    assign head_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0 prefixes into make/break events queued in a FWFT FIFO.
// Define SCANCODE_ASCII_EN to add shift tracking and an ASCII translation stored with each event.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iByte,
    input  logic       iByteValid,
    input  logic       iEventRead,
    output logic       oEventValid,
    output logic [7:0] oKeyCode,
    output logic       oExtended,
    output logic       oBreak,
    output logic [7:0] oAscii,
    output logic       oOverflow,
    output logic       oPrefixTimeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic [TW-1:0] timer_reg;
    logic          timeout_reg;
    logic          overflow_reg;
    logic          expire;
    logic          push_valid;
    logic          push_ext;
    logic          push_brk;
    ps2_event_t    push_event;
    ps2_event_t    head_event;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_dropped;

    always_comb begin
        state_next = state_reg;
        push_valid = 1'b0;
        push_ext   = 1'b0;
        push_brk   = 1'b0;
        expire     = 1'b0;
        if (iByteValid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (iByte == PS2_EXT) begin
                        state_next = ST_GOT_E0;
                    end else if (iByte == PS2_BRK) begin
                        state_next = ST_GOT_F0;
                    end else begin
                        push_valid = ~is_control_byte(iByte);
                    end
                end
                ST_GOT_E0: begin
                    if (iByte == PS2_BRK) begin
                        state_next = ST_GOT_E0F0;
                    end else if (iByte != PS2_EXT) begin
                        push_valid = 1'b1;
                        push_ext   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_GOT_F0: begin
                    if (iByte == PS2_EXT) begin
                        state_next = ST_GOT_E0F0;
                    end else if (iByte != PS2_BRK) begin
                        push_valid = 1'b1;
                        push_brk   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    if ((iByte != PS2_EXT) && (iByte != PS2_BRK)) begin
                        push_valid = 1'b1;
                        push_ext   = 1'b1;
                        push_brk   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            endcase
        end else if ((state_reg != ST_IDLE) && (timer_reg == TW'(TIMEOUT_CYCLES - 1))) begin
            // An arriving byte always beats the timeout, hence the else-branch.
            state_next = ST_IDLE;
            expire     = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg    <= ST_IDLE;
            timer_reg    <= '0;
            timeout_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timeout_reg <= expire;
            if (fifo_dropped) begin
                overflow_reg <= 1'b1;
            end
            if (iByteValid || expire) begin
                timer_reg <= '0;
            end else if (state_reg != ST_IDLE) begin
                timer_reg <= timer_reg + 1'b1;
            end
        end
    end

`ifdef SCANCODE_ASCII_EN
    logic shift_reg;

    // Only the plain shift codes count; E0 12 is a fake shift sent around some extended keys.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            shift_reg <= 1'b0;
        end else if (push_valid && !push_ext &&
                     ((iByte == PS2_LSHIFT) || (iByte == PS2_RSHIFT))) begin
            shift_reg <= ~push_brk;
        end
    end
`endif

    always_comb begin
        push_event      = '0;
        push_event.code = iByte;
        push_event.ext  = push_ext;
        push_event.brk  = push_brk;
`ifdef SCANCODE_ASCII_EN
        push_event.ascii = push_ext ? 8'h00 : ascii_lookup(iByte, shift_reg);
`endif
    end

    ps2_event_fifo #(
        .WIDTH ($bits(ps2_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (push_valid),
        .push_data (push_event),
        .pop       (iEventRead),
        .head_data (head_event),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .dropped   (fifo_dropped)
    );

    assign oEventValid    = ~fifo_empty;
    assign oKeyCode       = head_event.code;
    assign oExtended      = head_event.ext;
    assign oBreak         = head_event.brk;
    assign oOverflow      = overflow_reg;
    assign oPrefixTimeout = timeout_reg;
`ifdef SCANCODE_ASCII_EN
    assign oAscii = head_event.ascii;
`else
    assign oAscii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: byte table with expected events plus multi-cycle sequences.
// A second instance with a short timeout exercises the byte-versus-timeout collision.
module tb_ps2_scancode_decoder;

    localparam int TIMEOUT   = 50000;
    localparam int TIMEOUT_S = 16;
`ifdef SCANCODE_ASCII_EN
    localparam bit ASCII_EN = 1'b1;
`else
    localparam bit ASCII_EN = 1'b0;
`endif

    logic       Clock;
    logic       Reset;
    logic [7:0] iByte;
    logic       iByteValid;
    logic       iEventRead;

    logic       oEventValid, oExtended, oBreak, oOverflow, oPrefixTimeout;
    logic [7:0] oKeyCode, oAscii;
    logic       s_valid, s_ext, s_brk, s_ovf, s_pulse;
    logic [7:0] s_code, s_ascii;

    ps2_scancode_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TIMEOUT)) u_dut (
        .Clock(Clock), .Reset(Reset), .iByte(iByte), .iByteValid(iByteValid),
        .iEventRead(iEventRead), .oEventValid(oEventValid), .oKeyCode(oKeyCode),
        .oExtended(oExtended), .oBreak(oBreak), .oAscii(oAscii),
        .oOverflow(oOverflow), .oPrefixTimeout(oPrefixTimeout)
    );

    ps2_scancode_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TIMEOUT_S)) u_dut_short (
        .Clock(Clock), .Reset(Reset), .iByte(iByte), .iByteValid(iByteValid),
        .iEventRead(iEventRead), .oEventValid(s_valid), .oKeyCode(s_code),
        .oExtended(s_ext), .oBreak(s_brk), .oAscii(s_ascii),
        .oOverflow(s_ovf), .oPrefixTimeout(s_pulse)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] b;
        logic       ev;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] asc;
    } vec_t;

    vec_t vecs [64];
    int   nv;
    int   n_vec;
    int   n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [7:0] a(input logic [7:0] x);
        return ASCII_EN ? x : 8'h00;
    endfunction

    task automatic add(input logic [7:0] b, input logic ev, input logic [7:0] code,
                       input logic ext, input logic brk, input logic [7:0] asc);
        vecs[nv] = '{b, ev, code, ext, brk, asc};
        nv++;
    endtask

    task automatic strobe(input logic [7:0] b);
        iByte = b;
        iByteValid = 1'b1;
        @(posedge Clock); #1;
        iByteValid = 1'b0;
    endtask

    task automatic pop();
        iEventRead = 1'b1;
        @(posedge Clock); #1;
        iEventRead = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] codes [5];
        int cnt;
        int first;

        n_vec = 0; n_bad = 0; nv = 0;
        codes[0] = 8'h15; codes[1] = 8'h1D; codes[2] = 8'h24; codes[3] = 8'h2D; codes[4] = 8'h2C;

        // byte, event?, code, ext, brk, ascii
        add(8'h1C, 1, 8'h1C, 0, 0, a(8'h61));
        add(8'hF0, 0, 8'h00, 0, 0, 8'h00);
        add(8'h1C, 1, 8'h1C, 0, 1, a(8'h61));
        add(8'hE0, 0, 8'h00, 0, 0, 8'h00);
        add(8'hF0, 0, 8'h00, 0, 0, 8'h00);
        add(8'h75, 1, 8'h75, 1, 1, 8'h00);
        add(8'hE0, 0, 8'h00, 0, 0, 8'h00);
        add(8'h75, 1, 8'h75, 1, 0, 8'h00);
        add(8'hAA, 0, 8'h00, 0, 0, 8'h00);
        add(8'hFA, 0, 8'h00, 0, 0, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0, 8'h00);
        add(8'hEE, 0, 8'h00, 0, 0, 8'h00);
        add(8'hFE, 0, 8'h00, 0, 0, 8'h00);
        add(8'hFF, 0, 8'h00, 0, 0, 8'h00);
        add(8'hE0, 0, 8'h00, 0, 0, 8'h00);
        add(8'hE0, 0, 8'h00, 0, 0, 8'h00);
        add(8'h6B, 1, 8'h6B, 1, 0, 8'h00);
        add(8'hF0, 0, 8'h00, 0, 0, 8'h00);
        add(8'hE0, 0, 8'h00, 0, 0, 8'h00);
        add(8'h74, 1, 8'h74, 1, 1, 8'h00);
        add(8'hE0, 0, 8'h00, 0, 0, 8'h00);
        add(8'hF0, 0, 8'h00, 0, 0, 8'h00);
        add(8'hF0, 0, 8'h00, 0, 0, 8'h00);
        add(8'hE0, 0, 8'h00, 0, 0, 8'h00);
        add(8'h70, 1, 8'h70, 1, 1, 8'h00);
        add(8'hF0, 0, 8'h00, 0, 0, 8'h00);
        add(8'hAA, 1, 8'hAA, 0, 1, 8'h00);
        add(8'hE0, 0, 8'h00, 0, 0, 8'h00);
        add(8'hFA, 1, 8'hFA, 1, 0, 8'h00);
        add(8'h12, 1, 8'h12, 0, 0, 8'h00);
        add(8'h1C, 1, 8'h1C, 0, 0, a(8'h41));
        add(8'hF0, 0, 8'h00, 0, 0, 8'h00);
        add(8'h12, 1, 8'h12, 0, 1, 8'h00);
        add(8'h1C, 1, 8'h1C, 0, 0, a(8'h61));
        add(8'h59, 1, 8'h59, 0, 0, 8'h00);
        add(8'h45, 1, 8'h45, 0, 0, a(8'h30));
        add(8'h1B, 1, 8'h1B, 0, 0, a(8'h53));
        add(8'hF0, 0, 8'h00, 0, 0, 8'h00);
        add(8'h59, 1, 8'h59, 0, 1, 8'h00);
        add(8'h29, 1, 8'h29, 0, 0, a(8'h20));
        add(8'h5A, 1, 8'h5A, 0, 0, a(8'h0D));
        add(8'hE0, 0, 8'h00, 0, 0, 8'h00);
        add(8'h5A, 1, 8'h5A, 1, 0, 8'h00);
        add(8'h0E, 1, 8'h0E, 0, 0, 8'h00);

        Reset = 1'b1; iByte = 8'h00; iByteValid = 1'b0; iEventRead = 1'b0;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;

        check("reset oEventValid", 32'(oEventValid), 32'(1'b0));
        check("reset oKeyCode", 32'(oKeyCode), 32'(8'h00));
        check("reset oExtended", 32'(oExtended), 32'(1'b0));
        check("reset oBreak", 32'(oBreak), 32'(1'b0));
        check("reset oAscii", 32'(oAscii), 32'(8'h00));
        check("reset oOverflow", 32'(oOverflow), 32'(1'b0));
        check("reset oPrefixTimeout", 32'(oPrefixTimeout), 32'(1'b0));

        // Latency: not valid in the strobe cycle, valid in the next.
        iByte = 8'h1C; iByteValid = 1'b1;
        #2 check("latency strobe cycle valid", 32'(oEventValid), 32'(1'b0));
        @(posedge Clock); #1 iByteValid = 1'b0;
        check("latency next cycle valid", 32'(oEventValid), 32'(1'b1));
        check("latency code", 32'(oKeyCode), 32'(8'h1C));
        pop();
        check("latency drained", 32'(oEventValid), 32'(1'b0));

        for (int i = 0; i < nv; i++) begin
            strobe(vecs[i].b);
            check($sformatf("vec%0d byte %h valid", i, vecs[i].b), 32'(oEventValid), 32'(vecs[i].ev));
            if (vecs[i].ev) begin
                check($sformatf("vec%0d code", i), 32'(oKeyCode), 32'(vecs[i].code));
                check($sformatf("vec%0d ext", i), 32'(oExtended), 32'(vecs[i].ext));
                check($sformatf("vec%0d brk", i), 32'(oBreak), 32'(vecs[i].brk));
                check($sformatf("vec%0d ascii", i), 32'(oAscii), 32'(vecs[i].asc));
                pop();
            end
        end

        // Pops on an empty FIFO must not disturb the pointers.
        pop(); pop();
        check("empty pop valid", 32'(oEventValid), 32'(1'b0));
        strobe(8'h2C);
        check("after empty pop valid", 32'(oEventValid), 32'(1'b1));
        check("after empty pop code", 32'(oKeyCode), 32'(8'h2C));
        pop();

        // Five makes, no reads: four kept, overflow set.
        do_reset();
        for (int k = 0; k < 5; k++) strobe(codes[k]);
        check("ovf flag", 32'(oOverflow), 32'(1'b1));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf head%0d", k), 32'(oKeyCode), 32'(codes[k]));
            pop();
        end
        check("ovf drained", 32'(oEventValid), 32'(1'b0));
        check("ovf sticky", 32'(oOverflow), 32'(1'b1));

        // Same again, popping in the 5th strobe cycle: push and pop both succeed while full.
        do_reset();
        for (int k = 0; k < 4; k++) strobe(codes[k]);
        iByte = codes[4]; iByteValid = 1'b1; iEventRead = 1'b1;
        check("fullrw head0", 32'(oKeyCode), 32'(codes[0]));
        @(posedge Clock); #1;
        iByteValid = 1'b0; iEventRead = 1'b0;
        check("fullrw no overflow", 32'(oOverflow), 32'(1'b0));
        for (int k = 1; k < 5; k++) begin
            check($sformatf("fullrw head%0d", k), 32'(oKeyCode), 32'(codes[k]));
            pop();
        end
        check("fullrw drained", 32'(oEventValid), 32'(1'b0));

        // Reset mid-prefix with an event queued.
        strobe(8'h15);
        strobe(8'hE0);
        do_reset();
        check("midreset empty", 32'(oEventValid), 32'(1'b0));
        strobe(8'h1C);
        check("midreset valid", 32'(oEventValid), 32'(1'b1));
        check("midreset code", 32'(oKeyCode), 32'(8'h1C));
        check("midreset ext", 32'(oExtended), 32'(1'b0));
        pop();

        // Prefix timeout: F0 captured at edge 0, pulse visible after edge TIMEOUT.
        strobe(8'hF0);
        cnt = 0; first = -1;
        for (int i = 1; i <= TIMEOUT + 20; i++) begin
            @(posedge Clock); #1;
            if (oPrefixTimeout) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        check("timeout pulse count", 32'(cnt), 32'(1));
        check("timeout pulse cycle", 32'(first), 32'(TIMEOUT));
        check("timeout no event", 32'(oEventValid), 32'(1'b0));
        strobe(8'h1C);
        check("post-timeout valid", 32'(oEventValid), 32'(1'b1));
        check("post-timeout code", 32'(oKeyCode), 32'(8'h1C));
        check("post-timeout brk", 32'(oBreak), 32'(1'b0));
        check("post-timeout ext", 32'(oExtended), 32'(1'b0));
        pop();

        // Byte arriving in the expiry cycle wins over the timeout.
        do_reset();
        strobe(8'hF0);
        cnt = 0;
        repeat (TIMEOUT_S - 1) begin
            @(posedge Clock); #1;
            if (s_pulse) cnt++;
        end
        strobe(8'h1C);
        if (s_pulse) cnt++;
        @(posedge Clock); #1;
        if (s_pulse) cnt++;
        check("collision no pulse", 32'(cnt), 32'(0));
        check("collision valid", 32'(s_valid), 32'(1'b1));
        check("collision code", 32'(s_code), 32'(8'h1C));
        check("collision brk", 32'(s_brk), 32'(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
